// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl_if : hazard inputs and stage command outputs              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             mem_req_i;
  logic             mem_ack_i;
  logic             ex_redirect_i;
  logic             ex_is_load_i;
  logic [4:0]       ex_rd_addr_i;
  logic [4:0]       id_rs1_addr_i;
  logic [4:0]       id_rs2_addr_i;
  logic             id_rs1_used_i;
  logic             id_rs2_used_i;
  logic [1:0]       ctrl_pc_o;
  logic [1:0]       ctrl_if_id_o;
  logic [1:0]       ctrl_id_ex_o;
  logic [1:0]       ctrl_ex_mem_o;
  logic [1:0]       ctrl_mem_wb_o;
  logic             mem_timeout_o;
  logic             mem_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  // Pipeline side: supplies hazard status, consumes stage commands
  modport master (
    output mem_req_i, mem_ack_i, ex_redirect_i, ex_is_load_i, ex_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    input  ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
           mem_timeout_o, mem_err_o, stall_cnt_o
  );

  modport slave (
    input  mem_req_i, mem_ack_i, ex_redirect_i, ex_is_load_i, ex_rd_addr_i,
           id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
    output ctrl_pc_o, ctrl_if_id_o, ctrl_id_ex_o, ctrl_ex_mem_o, ctrl_mem_wb_o,
           mem_timeout_o, mem_err_o, stall_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_hazard_ctrl : stall/bubble sequencer with memory watchdog             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int                WAIT_W             = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX           = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX            = {CNT_W{1'b1}};
  localparam logic [1:0]        CTRL_STATE_DEFAULT = 2'd0;
  localparam logic [1:0]        CTRL_STATE_BLOCK   = 2'd1;
  localparam logic [1:0]        CTRL_STATE_BUBBLE  = 2'd2;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       timeout_hit;
  logic       mem_stall;
  logic       load_use;
  logic [1:0] ctrl_pc, ctrl_if_id, ctrl_id_ex, ctrl_ex_mem, ctrl_mem_wb;

  always_comb begin
    // Reset suppresses the watchdog so an abandoned wait raises nothing
    timeout_hit = hz.mem_req_i & ~hz.mem_ack_i & (wait_cnt_q == WAIT_MAX) & ~rst;
    mem_stall   = hz.mem_req_i & ~hz.mem_ack_i & ~timeout_hit;
    load_use    = hz.ex_is_load_i & (hz.ex_rd_addr_i != 5'd0) &
                  ((hz.id_rs1_used_i & (hz.id_rs1_addr_i == hz.ex_rd_addr_i)) |
                   (hz.id_rs2_used_i & (hz.id_rs2_addr_i == hz.ex_rd_addr_i)));

    ctrl_pc     = CTRL_STATE_DEFAULT;
    ctrl_if_id  = CTRL_STATE_DEFAULT;
    ctrl_id_ex  = CTRL_STATE_DEFAULT;
    ctrl_ex_mem = CTRL_STATE_DEFAULT;
    ctrl_mem_wb = CTRL_STATE_DEFAULT;
    if (rst) begin
      ctrl_pc     = CTRL_STATE_BUBBLE;
      ctrl_if_id  = CTRL_STATE_BUBBLE;
      ctrl_id_ex  = CTRL_STATE_BUBBLE;
      ctrl_ex_mem = CTRL_STATE_BUBBLE;
      ctrl_mem_wb = CTRL_STATE_BUBBLE;
    end else if (mem_stall) begin
      ctrl_pc     = CTRL_STATE_BLOCK;
      ctrl_if_id  = CTRL_STATE_BLOCK;
      ctrl_id_ex  = CTRL_STATE_BLOCK;
      ctrl_ex_mem = CTRL_STATE_BLOCK;
      ctrl_mem_wb = CTRL_STATE_BUBBLE;
    end else if (hz.ex_redirect_i) begin
      ctrl_if_id  = CTRL_STATE_BUBBLE;
      ctrl_id_ex  = CTRL_STATE_BUBBLE;
    end else if (load_use) begin
      ctrl_pc     = CTRL_STATE_BLOCK;
      ctrl_if_id  = CTRL_STATE_BLOCK;
      ctrl_id_ex  = CTRL_STATE_BUBBLE;
    end

    // Ack, timeout or a dropped request all end the wait in one step
    state_d    = mem_stall ? ST_MEM_WAIT : ST_RUN;
    wait_cnt_d = '0;
    if (mem_stall) begin
      wait_cnt_d = (state_q == ST_RUN) ? WAIT_W'(1) : wait_cnt_q + WAIT_W'(1);
    end

    mem_err_d   = mem_err_q | timeout_hit;
    stall_cnt_d = stall_cnt_q;
    if ((ctrl_pc != CTRL_STATE_DEFAULT) && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign hz.ctrl_pc_o     = ctrl_pc;
  assign hz.ctrl_if_id_o  = ctrl_if_id;
  assign hz.ctrl_id_ex_o  = ctrl_id_ex;
  assign hz.ctrl_ex_mem_o = ctrl_ex_mem;
  assign hz.ctrl_mem_wb_o = ctrl_mem_wb;
  assign hz.mem_timeout_o = timeout_hit;
  assign hz.mem_err_o     = mem_err_q;
  assign hz.stall_cnt_o   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : scoreboard bench, MEM_TIMEOUT=4, CNT_W=4             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;

  localparam logic [1:0] DEF = 2'd0;
  localparam logic [1:0] BLK = 2'd1;
  localparam logic [1:0] BUB = 2'd2;
  localparam int         TMO = 4;

  typedef struct packed {
    logic [9:0] ctrl;
    logic       tmo;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  int   m_wait = 0;
  bit   m_err  = 1'b0;
  int   m_cnt  = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(4)) u_if ();

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (TMO),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (u_if.slave)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; the expected outputs come from an independent model
  task automatic drive(input bit r, input bit req, input bit ack, input bit redir,
                       input bit isld, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input bit u1, input bit u2);
    bit   lu, th, ms;
    exp_t e;
    @(posedge clk);
    #1;
    rst                  = r;
    u_if.mem_req_i       = req;
    u_if.mem_ack_i       = ack;
    u_if.ex_redirect_i   = redir;
    u_if.ex_is_load_i    = isld;
    u_if.ex_rd_addr_i    = rd;
    u_if.id_rs1_addr_i   = rs1;
    u_if.id_rs2_addr_i   = rs2;
    u_if.id_rs1_used_i   = u1;
    u_if.id_rs2_used_i   = u2;

    lu = isld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    th = !r && req && !ack && (m_wait == TMO);
    ms = req && !ack && !th;
    if (r)          e.ctrl = {BUB, BUB, BUB, BUB, BUB};
    else if (ms)    e.ctrl = {BLK, BLK, BLK, BLK, BUB};
    else if (redir) e.ctrl = {DEF, BUB, BUB, DEF, DEF};
    else if (lu)    e.ctrl = {BLK, BLK, BUB, DEF, DEF};
    else            e.ctrl = {DEF, DEF, DEF, DEF, DEF};
    e.tmo = th;
    e.err = m_err;
    e.cnt = 4'(m_cnt);
    sb_q.push_back(e);

    if (r) begin
      m_wait = 0;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else begin
      m_wait = ms ? m_wait + 1 : 0;
      m_err  = m_err | th;
      if (e.ctrl[9:8] != DEF && m_cnt < 15) m_cnt++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val("ctrl", 32'({u_if.ctrl_pc_o, u_if.ctrl_if_id_o, u_if.ctrl_id_ex_o,
                             u_if.ctrl_ex_mem_o, u_if.ctrl_mem_wb_o}), 32'(e.ctrl));
      check_val("timeout", 32'(u_if.mem_timeout_o), 32'(e.tmo));
      check_val("err", 32'(u_if.mem_err_o), 32'(e.err));
      check_val("stall_cnt", 32'(u_if.stall_cnt_o), 32'(e.cnt));
    end
  end

  initial begin
    u_if.mem_req_i     = 1'b0;
    u_if.mem_ack_i     = 1'b0;
    u_if.ex_redirect_i = 1'b0;
    u_if.ex_is_load_i  = 1'b0;
    u_if.ex_rd_addr_i  = 5'd0;
    u_if.id_rs1_addr_i = 5'd0;
    u_if.id_rs2_addr_i = 5'd0;
    u_if.id_rs1_used_i = 1'b0;
    u_if.id_rs2_used_i = 1'b0;

    do_reset();
    do_reset();
    idle(1);

    // Load-use on rs2, then rd=0, rs1 path and an unused source
    drive(0, 0, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
    idle(1);
    @(negedge clk);
    check_val("lu_cnt", 32'(u_if.stall_cnt_o), 32'd1);
    drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    drive(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd3, 1, 0);
    drive(0, 0, 0, 0, 1, 5'd7, 5'd7, 5'd7, 0, 0);
    drive(0, 0, 0, 0, 0, 5'd9, 5'd9, 5'd9, 1, 1);

    // Memory wait acked after 3 cycles, then a fresh access to prove wait_cnt cleared
    do_reset();
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);
    @(negedge clk);
    check_val("mem_cnt", 32'(u_if.stall_cnt_o), 32'd3);
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);

    // Watchdog: never acked, timeout on the 5th cycle, error stays sticky
    do_reset();
    for (int i = 0; i < 6; i++) drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);
    @(negedge clk);
    check_val("err_sticky", 32'(u_if.mem_err_o), 32'd1);
    do_reset();
    idle(1);

    // Redirect beats load-use; redirect held under a memory stall
    drive(0, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0);
    drive(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);

    // Reset in the middle of a memory wait
    do_reset();
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(1);

    // Counter saturation over 20 stall cycles
    do_reset();
    for (int i = 0; i < 20; i++) drive(0, 0, 0, 0, 1, 5'd6, 5'd6, 5'd0, 1, 0);
    idle(1);
    @(negedge clk);
    check_val("sat_cnt", 32'(u_if.stall_cnt_o), 32'd15);

    @(negedge clk);
    #1;
    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
